// File: rtl/adc_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_sequencer
//  Description : Conversion sequencer and decimator for the multislope ADC
//                core. Raises the level-sensitive adc_start, waits for the
//                core's adc_done level, accumulates 2^AVG_LOG2 results and
//                presents the truncated mean on a valid/ready output port.
//  Ports       : clk, rst_n (async active-low)
//                enable       - run request (level)
//                adc_start    - start level to ADC core
//                adc_done     - ADC final-state level
//                adc_result   - 8-bit conversion result
//                avg_data     - mean of the last N captured results
//                avg_valid    - avg_data valid, held until avg_ready
//                avg_ready    - consumer accept
//                timeout_err  - sticky conversion-timeout flag
//                busy         - sequencer not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_sequencer #(
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       adc_start,
    input  logic       adc_done,
    input  logic [7:0] adc_result,
    output logic [7:0] avg_data,
    output logic       avg_valid,
    input  logic       avg_ready,
    output logic       timeout_err,
    output logic       busy
);

    localparam int                ACC_W      = 8 + AVG_LOG2;
    localparam int                CNT_W      = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0]  C_N        = CNT_W'(1 << AVG_LOG2);
    // Counter value seen on the TIMEOUT-th WAIT_DONE cycle (counter starts at 0).
    localparam logic [15:0]       C_TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_RELEASE   = 3'd3,
        S_OUTPUT    = 3'd4
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        tmo_q;
    logic               adc_start_q;
    logic [7:0]         avg_data_q;
    logic               avg_valid_q;
    logic               timeout_err_q;
    logic               busy_q;

    // Accumulator is wide enough for N full-scale samples, so no overflow.
    assign acc_d = acc_q + ACC_W'(adc_result);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            adc_start_q   <= 1'b0;
            avg_data_q    <= '0;
            avg_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    adc_start_q <= 1'b0;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    if (!enable) begin
                        timeout_err_q <= 1'b0;
                    end
                    // A done level left over from a previous run must fall
                    // before the core can accept a new start.
                    if (enable && !adc_done) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    tmo_q <= '0;
                    if (!enable) begin
                        adc_start_q <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        state_q     <= S_RELEASE;
                    end else begin
                        adc_start_q <= 1'b1;
                        state_q     <= S_WAIT_DONE;
                    end
                end

                S_WAIT_DONE: begin
                    if (!enable) begin
                        adc_start_q <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        state_q     <= S_RELEASE;
                    end else if (adc_done) begin
                        acc_q       <= acc_d;
                        cnt_q       <= cnt_q + CNT_W'(1);
                        adc_start_q <= 1'b0;
                        state_q     <= S_RELEASE;
                    end else if (tmo_q == C_TMO_LAST) begin
                        // Partial batch is discarded so the next word is clean.
                        adc_start_q   <= 1'b0;
                        timeout_err_q <= 1'b1;
                        acc_q         <= '0;
                        cnt_q         <= '0;
                        state_q       <= S_RELEASE;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end

                S_RELEASE: begin
                    if (!adc_done) begin
                        if (cnt_q == C_N) begin
                            // Mean by truncation: drop the low AVG_LOG2 bits.
                            avg_data_q  <= acc_q[ACC_W-1 -: 8];
                            avg_valid_q <= 1'b1;
                            state_q     <= S_OUTPUT;
                        end else if (enable) begin
                            state_q <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                S_OUTPUT: begin
                    if (avg_ready) begin
                        avg_valid_q <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    adc_start_q <= 1'b0;
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign adc_start   = adc_start_q;
    assign avg_data    = avg_data_q;
    assign avg_valid   = avg_valid_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire
